sync_slow: RTL and testbench

SYNC_SLOW -- requirements
Module: sync_slow

---
 rtl/sync_slow_pkg.sv | 10 +
 rtl/sync_slow_bit_sync.sv | 29 ++
 rtl/sync_slow.sv | 52 +++++
 tb/tb_sync_slow.sv | 116 +++++++++++
 4 files changed

// File: rtl/sync_slow_pkg.sv
// Shared defaults and data word type for the slow-clock-domain receive synchronizer.
// Holds no logic; imported by sync_slow and by anything sizing data to its defaults.
package sync_slow_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;

  typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/sync_slow_bit_sync.sv
// Multi-flop synchronizer for one level signal; q follows d after STAGES clk_rx edges.
// No backpressure: the input is sampled every cycle and never stalled.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_rx,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("bit_sync: STAGES must be in 2..4");
  end

  logic [STAGES-1:0] sync_q;

  // d goes straight into the first flop: nothing combinational ahead of it.
  always_ff @(posedge clk_rx) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sync_slow.sv
// Captures sdata on the rising edge of synchronized vi; vo/rdata/snt update SYNC_STAGES edges after vi is first sampled high.
// Backpressure via four-phase handshake: snt holds until synchronized vi drops, and no new request is taken before that.
module sync_slow
  import sync_slow_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk_rx,
  input  logic              reset,
  input  logic              vi,
  input  logic [DATA_W-1:0] sdata,
  output logic              vo,
  output logic [DATA_W-1:0] rdata,
  output logic              snt
);

  logic vi_sync;
  logic vi_hist;
  logic req_rise;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_bit_sync (
    .clk_rx (clk_rx),
    .reset  (reset),
    .d      (vi),
    .q      (vi_sync)
  );

  // vi_hist only returns to 0 once vi_sync has been seen low, which blocks re-detection.
  assign req_rise = vi_sync & ~vi_hist;

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      vi_hist <= 1'b0;
      vo      <= 1'b0;
      snt     <= 1'b0;
      rdata   <= '0;
    end else begin
      vi_hist <= vi_sync;
      vo      <= req_rise;
      if (req_rise) begin
        rdata <= sdata;
        snt   <= 1'b1;
      end else if (!vi_sync) begin
        snt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_slow.sv
// Scoreboard bench for sync_slow: expected capture words are queued when a request is driven
// and compared against rdata whenever vo pulses; handshake timing is checked cycle by cycle.
module tb_sync_slow;
  import sync_slow_pkg::*;

  localparam int N = 2;

  logic  clk_rx = 1'b0;
  logic  reset  = 1'b1;
  logic  vi     = 1'b0;
  data_t sdata  = '0;
  logic  vo;
  data_t rdata;
  logic  snt;

  int    n_checks    = 0;
  int    n_errors    = 0;
  int    pulses      = 0;
  int    exp_pulses  = 0;
  data_t exp_q[$];

  sync_slow #(
    .DATA_W      (32),
    .SYNC_STAGES (N)
  ) dut (
    .clk_rx (clk_rx),
    .reset  (reset),
    .vi     (vi),
    .sdata  (sdata),
    .vo     (vo),
    .rdata  (rdata),
    .snt    (snt)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Every vo pulse must consume exactly one queued expectation.
  always @(negedge clk_rx) begin
    if (vo === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) check("vo_unexpected", 1, 0);
      else                   check("rdata_at_vo", rdata, exp_q.pop_front());
    end
  end

  // Drive one request held high for hi cycles, then low for lo cycles.
  // After E(N) the output is visible at the (N+1)th falling edge; d_late replaces sdata there.
  task automatic xfer(input data_t d, input int hi, input int lo, input data_t d_late);
    sdata = d;
    vi    = 1'b1;
    exp_q.push_back(d);
    exp_pulses++;
    for (int k = 1; k <= hi; k++) begin
      @(negedge clk_rx);
      check("vo_while_vi_high", vo, (k == N + 1));
      check("snt_while_vi_high", snt, (k >= N + 1));
      if (k == N + 1) sdata = d_late;
    end
    vi = 1'b0;
    for (int m = 1; m <= lo; m++) begin
      @(negedge clk_rx);
      check("vo_while_vi_low", vo, 0);
      check("snt_while_vi_low", snt, (m <= N));
    end
    check("rdata_hold", rdata, d);
  endtask

  initial begin
    // Reset for one cycle with vi low.
    @(negedge clk_rx);
    reset = 1'b0;
    check("reset_vo", vo, 0);
    check("reset_snt", snt, 0);
    check("reset_rdata", rdata, 0);

    repeat (2) @(negedge clk_rx);

    // Single transfer then back-to-back after 3 idle cycles.
    xfer(32'h00A98AC7, 3, 3, 32'h00A98AC7);
    xfer(32'hDEADBEEF, 3, 3, 32'hDEADBEEF);

    // Long request: single pulse, snt held for the whole high time.
    xfer(32'h12345678, 20, 4, 32'h12345678);

    // Reset on E1 while vi is high: pending transfer dropped, re-captured after release.
    sdata = 32'hCAFEF00D;
    vi    = 1'b1;
    @(negedge clk_rx);
    reset = 1'b1;
    @(negedge clk_rx);
    check("midreset_vo", vo, 0);
    check("midreset_snt", snt, 0);
    check("midreset_rdata", rdata, 0);
    reset = 1'b0;
    xfer(32'hCAFEF00D, 4, 4, 32'hCAFEF00D);

    // sdata changes one cycle after detection; capture must keep the old word.
    xfer(32'hAAAA5555, 6, 4, 32'h5555AAAA);

    repeat (3) @(negedge clk_rx);
    check("pulse_count", pulses, exp_pulses);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
